// File: rtl/intr_ctrl_pkg.sv
// Shared definitions for the vectored interrupt controller: FSM encoding,
// default vector layout and the return-from-interrupt opcode shared with uc.
package intr_ctrl_pkg;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_SERVICE = 1'b1
    } intr_state_e;

    // Default vector table: vector 0 at 0x3F0, one vector every 4 words.
    localparam int unsigned VEC_BASE_DFLT  = 32'h0000_03F0;
    localparam int          VEC_SHIFT_DFLT = 2;

    // Return-from-interrupt opcode, decoded by uc to raise reti.
    localparam int          OPCODE_W = 4;
    localparam logic [OPCODE_W-1:0] OP_RETI = 4'hD;

endpackage : intr_ctrl_pkg

// File: rtl/intr_ctrl_if.sv
// Bundle between the CPU side (master: request lines, mask writes, uc status)
// and the interrupt controller (slave: take, vector and status outputs).
interface intr_ctrl_if #(
    parameter int N_IRQ  = 4,
    parameter int ADDR_W = 10
);
    logic [N_IRQ-1:0]  irq;
    logic              mask_we;
    logic [N_IRQ-1:0]  mask_wdata;
    logic              boundary_ok;
    logic              reti;
    logic              int_take;
    logic [ADDR_W-1:0] int_vector;
    logic [N_IRQ-1:0]  in_service;
    logic [N_IRQ-1:0]  pending;
    logic [N_IRQ-1:0]  mask;

    modport master (
        output irq, mask_we, mask_wdata, boundary_ok, reti,
        input  int_take, int_vector, in_service, pending, mask
    );

    modport slave (
        input  irq, mask_we, mask_wdata, boundary_ok, reti,
        output int_take, int_vector, in_service, pending, mask
    );
endinterface : intr_ctrl_if

// File: rtl/intr_ctrl_prio_enc.sv
// Combinational fixed-priority encoder: the lowest set request index wins.
module prio_enc #(
    parameter int N_IRQ = 4,
    parameter int ID_W  = (N_IRQ > 1) ? $clog2(N_IRQ) : 1
) (
    input  logic [N_IRQ-1:0] req,
    output logic [ID_W-1:0]  id,
    output logic             valid
);

    // Scanning downwards lets the lowest index overwrite any higher one.
    always_comb begin
        id = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (req[i]) id = ID_W'(i);
        end
    end

    assign valid = |req;

endmodule : prio_enc

// File: rtl/intr_ctrl.sv
// Vectored interrupt controller: rising-edge capture, mask, fixed priority,
// single-level nesting with a take at a safe instruction boundary.
module intr_ctrl
    import intr_ctrl_pkg::*;
#(
    parameter int                N_IRQ     = 4,
    parameter int                ADDR_W    = 10,
    parameter logic [ADDR_W-1:0] VEC_BASE  = ADDR_W'(VEC_BASE_DFLT),
    parameter int                VEC_SHIFT = VEC_SHIFT_DFLT
) (
    input  logic       clk,
    input  logic       reset,
    intr_ctrl_if.slave bus
);

    localparam int ID_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

    intr_state_e       state_q, state_d;
    logic [N_IRQ-1:0]  irq_q;
    logic [N_IRQ-1:0]  pending_q, pending_d;
    logic [N_IRQ-1:0]  mask_q, mask_d;
    logic [N_IRQ-1:0]  in_service_q, in_service_d;

    logic [N_IRQ-1:0]  rise;
    logic [N_IRQ-1:0]  req;
    logic [ID_W-1:0]   sel;
    logic              sel_valid;
    logic [N_IRQ-1:0]  sel_onehot;
    logic [N_IRQ-1:0]  take_clr;
    logic [ADDR_W-1:0] sel_ext;
    logic              take;

    assign req        = pending_q & mask_q;
    assign sel_onehot = N_IRQ'(1) << sel;

    prio_enc #(
        .N_IRQ (N_IRQ),
        .ID_W  (ID_W)
    ) u_prio_enc (
        .req   (req),
        .id    (sel),
        .valid (sel_valid)
    );

    // ------------------------------------------------------------------
    // State register (FSM plus edge-capture, pending and mask registers)
    // ------------------------------------------------------------------
    // NOTE: non-blocking assignments here so every register samples the
    // pre-edge values; blocking would make later lines see updated state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            pending_q    <= '0;
            mask_q       <= '0;
            in_service_q <= '0;
            // Lines already high when reset releases must not look like a rise.
            irq_q        <= bus.irq;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            mask_q       <= mask_d;
            in_service_q <= in_service_d;
            irq_q        <= bus.irq;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // NOTE: every always_comb output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d      = state_q;
        in_service_d = in_service_q;
        unique case (state_q)
            ST_IDLE: begin
                if (take) begin
                    state_d      = ST_SERVICE;
                    in_service_d = sel_onehot;
                end
            end
            ST_SERVICE: begin
                if (bus.reti) begin
                    state_d      = ST_IDLE;
                    in_service_d = '0;
                end
            end
            default: begin
                state_d      = ST_IDLE;
                in_service_d = '0;
            end
        endcase
    end

    // Set has priority over the take clear so a rise coinciding with its own
    // take is kept as a fresh event; repeated rises simply re-set the bit.
    assign rise      = bus.irq & ~irq_q;
    assign take_clr  = take ? sel_onehot : '0;
    assign pending_d = (pending_q & ~take_clr) | rise;
    assign mask_d    = bus.mask_we ? bus.mask_wdata : mask_q;

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        take = 1'b0;
        if (state_q == ST_IDLE) begin
            take = sel_valid & bus.boundary_ok;
        end
    end

    // Vector follows sel continuously; it only means something while int_take=1.
    assign sel_ext        = ADDR_W'(sel);
    assign bus.int_vector = VEC_BASE + (sel_ext << VEC_SHIFT);
    assign bus.int_take   = take;
    assign bus.in_service = in_service_q;
    assign bus.pending    = pending_q;
    assign bus.mask       = mask_q;

endmodule : intr_ctrl

// File: tb/tb_intr_ctrl.sv
// Directed self-checking bench for intr_ctrl; expected values are hand-derived
// from the controller's behaviour (one-cycle edge-to-take latency, etc.).
module tb_intr_ctrl;

    localparam int N_IRQ  = 4;
    localparam int ADDR_W = 10;

    logic clk;
    logic reset;

    int n_checks = 0;
    int n_fail   = 0;

    intr_ctrl_if #(.N_IRQ(N_IRQ), .ADDR_W(ADDR_W)) bus ();

    intr_ctrl #(
        .N_IRQ     (N_IRQ),
        .ADDR_W    (ADDR_W),
        .VEC_BASE  (10'h3F0),
        .VEC_SHIFT (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are driven here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle after an input change, well before negedge.
    task automatic settle();
        #1;
    endtask

    task automatic do_reti();
        bus.reti = 1'b1;
        tick();
        bus.reti = 1'b0;
    endtask

    task automatic write_mask(input logic [N_IRQ-1:0] m);
        bus.mask_we    = 1'b1;
        bus.mask_wdata = m;
        tick();
        bus.mask_we    = 1'b0;
    endtask

    initial begin
        reset           = 1'b1;
        bus.irq         = '0;
        bus.mask_we     = 1'b0;
        bus.mask_wdata  = '0;
        bus.boundary_ok = 1'b0;
        bus.reti        = 1'b0;

        // Reset state
        tick();
        tick();
        settle();
        check("rst_in_service", 32'(bus.in_service), 32'h0);
        check("rst_pending",    32'(bus.pending),    32'h0);
        check("rst_mask",       32'(bus.mask),       32'h0);
        check("rst_take",       32'(bus.int_take),   32'h0);
        reset = 1'b0;
        tick();
        write_mask(4'b1111);
        settle();
        check("mask_write", 32'(bus.mask), 32'hF);
        bus.boundary_ok = 1'b1;

        // 1. Basic take of id 2
        bus.irq = 4'b0100;                 // cycle 0
        settle();
        check("t1_c0_take", 32'(bus.int_take), 32'h0);
        tick();                            // cycle 1
        settle();
        check("t1_c1_pending", 32'(bus.pending),    32'h4);
        check("t1_c1_take",    32'(bus.int_take),   32'h1);
        check("t1_c1_vector",  32'(bus.int_vector), 32'h3F8);
        tick();                            // cycle 2
        bus.irq = 4'b0000;
        settle();
        check("t1_c2_in_service", 32'(bus.in_service), 32'h4);
        check("t1_c2_pending",    32'(bus.pending),    32'h0);
        check("t1_c2_take",       32'(bus.int_take),   32'h0);
        tick();                            // cycle 3
        tick();                            // cycle 4
        tick();                            // cycle 5
        do_reti();                         // now cycle 6
        settle();
        check("t1_c6_in_service", 32'(bus.in_service), 32'h0);

        // 2. Priority: ids 3 and 1 rise together, id 1 first
        bus.irq = 4'b1010;
        tick();
        settle();
        check("t2_pending",  32'(bus.pending),    32'hA);
        check("t2_take1",    32'(bus.int_take),   32'h1);
        check("t2_vector1",  32'(bus.int_vector), 32'h3F4);
        tick();
        bus.irq = 4'b0000;
        settle();
        check("t2_in_service1", 32'(bus.in_service), 32'h2);
        check("t2_pending_rem", 32'(bus.pending),    32'h8);
        check("t2_blocked",     32'(bus.int_take),   32'h0);
        do_reti();
        settle();
        check("t2_take2",   32'(bus.int_take),   32'h1);
        check("t2_vector2", 32'(bus.int_vector), 32'h3FC);
        tick();
        settle();
        check("t2_in_service2", 32'(bus.in_service), 32'h8);
        do_reti();

        // 3. Masking and boundary
        write_mask(4'b1110);
        bus.irq = 4'b0001;
        tick();
        bus.irq = 4'b0000;
        settle();
        check("t3_masked_pending", 32'(bus.pending),  32'h1);
        check("t3_masked_take",    32'(bus.int_take), 32'h0);
        bus.boundary_ok = 1'b0;
        bus.irq = 4'b0010;
        tick();
        bus.irq = 4'b0000;
        settle();
        check("t3_bnd_pending", 32'(bus.pending),  32'h3);
        check("t3_bnd_take_a",  32'(bus.int_take), 32'h0);
        tick();
        settle();
        check("t3_bnd_take_b", 32'(bus.int_take), 32'h0);
        bus.boundary_ok = 1'b1;
        settle();
        check("t3_bnd_take_now", 32'(bus.int_take),   32'h1);
        check("t3_bnd_vector",   32'(bus.int_vector), 32'h3F4);
        tick();
        settle();
        check("t3_in_service", 32'(bus.in_service), 32'h2);
        check("t3_pending0",   32'(bus.pending),    32'h1);
        do_reti();
        settle();
        check("t3_still_masked", 32'(bus.int_take), 32'h0);
        write_mask(4'b1111);
        settle();
        check("t3_unmask_take",   32'(bus.int_take),   32'h1);
        check("t3_unmask_vector", 32'(bus.int_vector), 32'h3F0);
        tick();
        settle();
        check("t3_unmask_pending", 32'(bus.pending), 32'h0);
        do_reti();

        // 4. Service blocking and merge while servicing id 2
        bus.irq = 4'b0100;
        tick();
        settle();
        check("t4_take2", 32'(bus.int_take), 32'h1);
        tick();
        bus.irq = 4'b0101;
        settle();
        check("t4_in_service", 32'(bus.in_service), 32'h4);
        tick();
        bus.irq = 4'b0100;
        settle();
        check("t4_blk_take_a", 32'(bus.int_take), 32'h0);
        tick();
        bus.irq = 4'b0101;
        tick();
        settle();
        check("t4_merged_pending", 32'(bus.pending),  32'h1);
        check("t4_blk_take_b",     32'(bus.int_take), 32'h0);
        bus.reti = 1'b1;
        settle();
        check("t4_reti_cycle_take", 32'(bus.int_take), 32'h0);
        tick();
        bus.reti = 1'b0;
        bus.irq  = 4'b0000;
        settle();
        check("t4_after_reti_take", 32'(bus.int_take),   32'h1);
        check("t4_after_reti_vec",  32'(bus.int_vector), 32'h3F0);
        tick();
        settle();
        check("t4_in_service0", 32'(bus.in_service), 32'h1);
        do_reti();

        // 5. Reset while in SERVICE with a pending event and irq[3] held
        bus.irq = 4'b0001;
        tick();
        tick();
        bus.irq = 4'b1001;
        tick();
        settle();
        check("t5_pre_in_service", 32'(bus.in_service), 32'h1);
        check("t5_pre_pending",    32'(bus.pending),    32'h8);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        settle();
        check("t5_in_service", 32'(bus.in_service), 32'h0);
        check("t5_pending",    32'(bus.pending),    32'h0);
        check("t5_mask",       32'(bus.mask),       32'h0);
        write_mask(4'b1111);
        tick();
        settle();
        check("t5_no_event_pending", 32'(bus.pending),  32'h0);
        check("t5_no_event_take",    32'(bus.int_take), 32'h0);

        // 6. Set-wins: id 1 re-rises in its own take cycle
        bus.irq = 4'b0000;
        tick();
        bus.irq = 4'b0010;
        tick();
        bus.boundary_ok = 1'b0;
        bus.irq = 4'b0000;
        settle();
        check("t6_pending", 32'(bus.pending),  32'h2);
        check("t6_held",    32'(bus.int_take), 32'h0);
        tick();
        bus.boundary_ok = 1'b1;
        bus.irq = 4'b0010;
        settle();
        check("t6_take", 32'(bus.int_take), 32'h1);
        tick();
        settle();
        check("t6_in_service",  32'(bus.in_service), 32'h2);
        check("t6_pending_kept", 32'(bus.pending),   32'h2);
        do_reti();
        settle();
        check("t6_second_take",   32'(bus.int_take),   32'h1);
        check("t6_second_vector", 32'(bus.int_vector), 32'h3F4);
        tick();
        settle();
        check("t6_final_pending", 32'(bus.pending), 32'h0);
        do_reti();
        settle();
        check("t6_final_idle", 32'(bus.in_service), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_intr_ctrl
